// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_tx parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bit counter width for a word of the given length (WIDTH >= 2).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Parallel word handshake plus serial line of the piso_tx transmitter.
interface piso_tx_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sdo;
    logic             sdo_en;
    logic             frame_done;

    // Producer side: drives the word, observes the serial line.
    modport master (
        output din, din_valid,
        input  din_ready, sdo, sdo_en, frame_done
    );

    // Transmitter side.
    modport slave (
        input  din, din_valid,
        output din_ready, sdo, sdo_en, frame_done
    );

endinterface

// File: rtl/shift_reg_piso.sv
// Loadable WIDTH-bit shift register; the head bit is presented straight from a flop.
module shift_reg_piso #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             sdo_o
);

    logic [WIDTH-1:0] data_q, data_d;

    // Zeros are shifted in behind the word, so the head reads 0 once it drains.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        data_d = data_q;
        if (load_i) begin
            data_d = din_i;
        end else if (shift_i) begin
            data_d = MSB_FIRST ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign sdo_o = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word intake, one bit per clock, gapless streaming.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    piso_tx_if.slave  bus
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [0:0]     IDLE     = ST_IDLE;
    localparam logic [0:0]     SHIFT    = ST_SHIFT;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_done_q, frame_done_d;
    logic          last_bit;
    logic          accept;
    logic          load;
    logic          shift;

    // Ready depends only on state/counter, never on din_valid, so no comb loop to the producer.
    assign last_bit      = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign bus.din_ready = (state_q == IDLE) || last_bit;
    assign accept        = bus.din_valid && bus.din_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        shift   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    shift = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Registered so the pulse lines up with the final bit leaving the shift register.
        frame_done_d = (state_d == SHIFT) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    shift_reg_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .din_i   (bus.din),
        .sdo_o   (bus.sdo)
    );

    assign bus.sdo_en     = (state_q == SHIFT);
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: MSB-first and LSB-first instances driven by one producer.
module tb_piso_tx;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;

    exp_t exp_q[2][$];
    logic exp_ready    = 1'b1;
    int   acc_cnt      = 0;
    int   cyc          = 0;
    int   last_acc_cyc = 0;
    int   checks       = 0;
    int   errors       = 0;

    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(W)) if_m ();
    piso_tx_if #(.WIDTH(W)) if_l ();

    assign if_m.din       = din;
    assign if_m.din_valid = din_valid;
    assign if_l.din       = din;
    assign if_l.din_valid = din_valid;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(if_m));
    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(if_l));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Acceptance model: a word is taken whenever valid meets the expected ready.
    always @(posedge clk) begin
        cyc++;
        if (rst && din_valid && exp_ready) begin
            for (int i = 0; i < W; i++) begin
                exp_t e;
                e.last = (i == W - 1);
                e.b    = din[W-1-i];
                exp_q[0].push_back(e);
                e.b    = din[i];
                exp_q[1].push_back(e);
            end
            acc_cnt++;
            last_acc_cyc = cyc;
        end
    end

    task automatic mon(input int d, input logic sdo, input logic en,
                       input logic fd, input logic rdy);
        exp_t e;
        logic exp_en;
        exp_en = (exp_q[d].size() != 0);
        check($sformatf("sdo_en[%0d]", d), en, exp_en);
        if (exp_en) begin
            e = exp_q[d].pop_front();
            check($sformatf("sdo[%0d]", d), sdo, e.b);
            check($sformatf("frame_done[%0d]", d), fd, e.last);
        end else begin
            check($sformatf("idle_sdo[%0d]", d), sdo, 1'b0);
            check($sformatf("idle_frame_done[%0d]", d), fd, 1'b0);
        end
        check($sformatf("din_ready[%0d]", d), rdy, exp_q[d].size() == 0);
    endtask

    always @(negedge clk) begin
        mon(0, if_m.sdo, if_m.sdo_en, if_m.frame_done, if_m.din_ready);
        mon(1, if_l.sdo, if_l.sdo_en, if_l.frame_done, if_l.din_ready);
        exp_ready = (exp_q[0].size() == 0);
    end

    task automatic send(input logic [W-1:0] data);
        int start;
        start     = acc_cnt;
        din       = data;
        din_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start) break;
        end
        check("accept_timeout", 32'(acc_cnt != start), 1);
        din_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sdo_m"}, if_m.sdo, 1'b0);
        check({tag, "_en_m"}, if_m.sdo_en, 1'b0);
        check({tag, "_fd_m"}, if_m.frame_done, 1'b0);
        check({tag, "_rdy_m"}, if_m.din_ready, 1'b1);
        check({tag, "_sdo_l"}, if_l.sdo, 1'b0);
        check({tag, "_en_l"}, if_l.sdo_en, 1'b0);
        check({tag, "_fd_l"}, if_l.frame_done, 1'b0);
        check({tag, "_rdy_l"}, if_l.din_ready, 1'b1);
    endtask

    initial begin
        int a0;
        rst       = 1'b0;
        din       = '0;
        din_valid = 1'b0;

        // Reset values must hold before any clock edge.
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single words: A5 exercises both bit orders, 01 the LSB-first head bit.
        send(8'hA5);
        repeat (10) @(posedge clk);
        #1;
        send(8'h01);
        repeat (10) @(posedge clk);
        #1;

        // Back-to-back with valid held: the second accept lands exactly W edges later.
        send(8'hF0);
        a0 = last_acc_cyc;
        send(8'h0F);
        check("b2b_accept_gap", 32'(last_acc_cyc - a0), W);
        repeat (20) @(posedge clk);
        #1;

        // Valid raised mid-word is held off until the last bit cycle.
        send(8'h00);
        a0 = last_acc_cyc;
        repeat (2) @(posedge clk);
        #1;
        din       = 8'hFF;
        din_valid = 1'b1;
        #1;
        check("ignored_ready_m", if_m.din_ready, 1'b0);
        check("ignored_ready_l", if_l.din_ready, 1'b0);
        send(8'hFF);
        check("pending_accept_gap", 32'(last_acc_cyc - a0), W);
        repeat (12) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a word, between clock edges.
        send(8'hA5);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        #1;
        check_reset_outputs("midword_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send(8'h3C);
        repeat (12) @(posedge clk);
        #1;

        check("words_accepted", acc_cnt, 8);
        check("drained_m", exp_q[0].size(), 0);
        check("drained_l", exp_q[1].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per clock, with a bit-enable strobe.
- It is the transmit end of the single-bit serial link whose receiver is the DFF-based serial capture chain.
- It sits between a parallel producer (register/FIFO) and the serial line.
- Back-to-back words stream gaplessly.

Parameters:
- WIDTH, 8, bits per word (>=2).
- MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = din[0] first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  WIDTH  parallel word to send.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block accepts din this cycle.
- sdo  output  1  serial data out, registered.
- sdo_en  output  1  high while sdo carries a valid bit, registered.
- frame_done  output  1  one-cycle pulse coincident with the last bit of a word, registered.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - state=IDLE, shift register=0, bit counter=0.
  - sdo=0, sdo_en=0, frame_done=0.
  - din_ready follows state, so it reads 1 while in reset and immediately after release.
- Handshake:
  - A word is accepted on a rising edge where din_valid & din_ready = 1.
  - din is sampled only at that edge; din may change freely otherwise.
  - din_ready is combinational from state/counter only, never from din_valid: din_ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1).
- FSM states: IDLE, SHIFT.
  - IDLE: sdo_en=0, sdo holds 0. On accept: load shift reg with din, cnt=0, go to SHIFT.
  - SHIFT: each cycle present the current bit on sdo with sdo_en=1; cnt increments.
  - At cnt==WIDTH-1 with an accept: reload, cnt=0, stay in SHIFT (gapless).
  - At cnt==WIDTH-1 without an accept: go to IDLE.
- Latency:
  - First bit appears on sdo the cycle after the accepting edge (registered outputs).
  - A word occupies exactly WIDTH consecutive sdo_en cycles.
- Bit order:
  - MSB_FIRST=1: sdo sequence din[WIDTH-1] .. din[0].
  - MSB_FIRST=0: sdo sequence din[0] .. din[WIDTH-1].
- frame_done is high on the same cycle that sdo carries the final bit of a word. It is low otherwise.
- Counter:
  - Width is $clog2(WIDTH).
  - It wraps only via reload to 0 and never exceeds WIDTH-1.
- Simultaneous events:
  - din_valid during a SHIFT cycle where cnt<WIDTH-1 is ignored; din_ready=0 there.
  - The producer must hold din_valid until it sees ready.
- Reset mid-word:
  - All outputs drop to their reset values asynchronously.
  - The partial word is discarded, with no frame_done.
  - After release the block is in IDLE with din_ready=1.
- While idle, sdo=0 and sdo_en=0 with no glitches; all outputs come straight from flops.

Decomposition:
- Package piso_pkg:
  - state enum typedef (IDLE, SHIFT).
  - localparam function for the counter width.
- One natural sub-module: shift_reg_piso. It holds the WIDTH-bit loadable shift register with load, shift and MSB_FIRST direction, built from the team's dff cells.
- The FSM, counter and handshake stay in the piso_tx top.

Test Plan:
1. Reset/idle: hold rst=0 for 3 cycles, release, din_valid=0 for 5 cycles -> sdo=0, sdo_en=0, frame_done=0, din_ready=1 throughout.
2. Single word, MSB_FIRST=1, WIDTH=8: din=8'hA5 accepted at cycle 0 -> cycles 1-8 sdo=1,0,1,0,0,1,0,1 with sdo_en=1; frame_done=1 at cycle 8 only; din_ready=1 at cycle 8; cycle 9 sdo_en=0.
3. LSB-first: MSB_FIRST=0, din=8'h01 -> sdo=1 on the first bit cycle, then seven 0s.
4. Back-to-back: 8'hF0 then 8'h0F, din_valid held high -> 16 consecutive sdo_en cycles, sdo=11110000_00001111, frame_done pulses at cycles 8 and 16, second word accepted at cycle 8.
5. Ignored valid: assert din_valid with din=8'hFF at cycle 3 of word 8'h00 -> din_ready=0 and the stream stays all 0s. The pending word is accepted at cycle 8, and its first bit appears at cycle 9.
6. Reset mid-word: drive rst=0 asynchronously (between edges) at bit 4 of 8'hA5 -> sdo, sdo_en and frame_done go to 0 immediately, with no frame_done. After release, a new word 8'h3C transmits correctly from bit 0.
